// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      SZ_H, SZ_HU: return off[0];
      SZ_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store mask and data replication, load extraction and extension.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword lanes look only at off[1], so an odd offset falls back to its aligned half.
    half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
    mask      = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    case (size)
      SZ_B: begin
        mask      = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        mask      = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        mask      = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      SZ_BU:   rdata_ext = {24'b0, byte_sel};
      SZ_HU:   rdata_ext = {16'b0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller with timeout; MEM_MISALIGN_TRAP_EN makes
// misaligned halfword/word accesses complete immediately with an error.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [2:0]  i_req_size,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  // Memory handshake: o_mem_req holds with stable addr/data until a cycle with i_mem_gnt=1;
  // a load then waits for the first i_mem_rvalid=1 in a later cycle (never the grant cycle).

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        err_q;
  logic [7:0]  cnt;
  logic        req_in, misalign_in, timeout_hit;
  logic [3:0]  fmt_mask;
  logic [31:0] fmt_wdata, fmt_rdata;

  assign req_in      = i_req_ren | i_req_wen;
  // cnt reads 0 in the first REQ cycle, so this is the TIMEOUT-th REQ/WAIT cycle.
  assign timeout_hit = (cnt == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_in = is_misaligned(i_req_size, i_req_addr[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  mem_lane_fmt u_fmt (
    .size      (size_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (i_mem_rdata),
    .mask      (fmt_mask),
    .wdata_rep (fmt_wdata),
    .rdata_ext (fmt_rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req_in) state_nx = misalign_in ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (i_mem_gnt)        state_nx = we_q ? ST_DONE : ST_WAIT;
        else if (timeout_hit) state_nx = ST_DONE;
      end
      ST_WAIT: if (i_mem_rvalid || timeout_hit) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (req_in) begin
          we_q    <= i_req_wen;
          size_q  <= i_req_size;
          addr_q  <= i_req_addr;
          wdata_q <= i_req_wdata;
          rdata_q <= '0;
          err_q   <= misalign_in;
          cnt     <= '0;
        end
        ST_REQ, ST_WAIT: begin
          cnt <= cnt + 8'd1;
          if (state == ST_WAIT && i_mem_rvalid) begin
            rdata_q <= fmt_rdata;
          end else if (timeout_hit && !(state == ST_REQ && i_mem_gnt)) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign o_stall     = ~i_rst & ((state == ST_IDLE && req_in) || state == ST_REQ || state == ST_WAIT);
  assign o_done      = (state == ST_DONE);
  assign o_rdata     = o_done ? rdata_q : '0;
  assign o_err       = o_done & err_q;
  assign o_mem_req   = (state == ST_REQ);
  assign o_mem_we    = o_mem_req & we_q;
  assign o_mem_addr  = o_mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign o_mem_wdata = o_mem_we ? fmt_wdata : '0;
  assign o_mem_mask  = o_mem_we ? fmt_mask : 4'b0000;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with TIMEOUT=4 and a scripted memory responder.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_ren, i_req_wen;
  logic [2:0]  i_req_size;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_stall, o_done, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];  // {err, rdata} per access, in issue order

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_ren(i_req_ren), .i_req_wen(i_req_wen), .i_req_size(i_req_size),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every o_done pulse retires the oldest expected result.
  always @(negedge i_clk) begin
    if (!i_rst && o_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got err=%0b rdata=%h, expected no completion", o_err, o_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({o_err, o_rdata} !== e) begin
          errors++;
          $display("FAIL sb_result: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                   o_err, o_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] w;
    if (size[1:0] == 2'b01) w = word >> (addr[1] ? 16 : 0);
    else                    w = word >> (8 * int'(addr[1:0]));
    case (size)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return word;
      3'b100:  return {24'b0, w[7:0]};
      3'b101:  return {16'b0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_trap(input logic [2:0] size, input logic [31:0] addr);
    return TRAP && (((size == 3'b001 || size == 3'b101) && addr[0]) ||
                    (size == 3'b010 && addr[1:0] != 2'b00));
  endfunction

  // Presents one request (entered and left at a negedge in IDLE) and plays the memory side.
  // gnt_dly: REQ cycles before grant (-1 never); rv_dly: WAIT cycles before rvalid (-1 never).
  task automatic run_access(input logic ren, input logic wen, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int gnt_dly, input int rv_dly,
                            input bit early_rv, output int lat, output int n_req,
                            output bit wait_seen, output bit stall0, output bit done_req,
                            output logic [31:0] m_addr, output logic [31:0] m_wdata,
                            output logic [3:0] m_mask, output logic m_we);
    int req_i, wait_i;
    lat = -1; n_req = 0; wait_seen = 0; done_req = 0;
    m_addr = '0; m_wdata = '0; m_mask = '0; m_we = 0; req_i = 0; wait_i = 0;
    i_req_ren = ren; i_req_wen = wen; i_req_size = size; i_req_addr = addr; i_req_wdata = wdata;
    #1 stall0 = o_stall;
    for (int c = 1; c <= 30; c++) begin
      @(posedge i_clk); #1;
      i_req_ren = 0; i_req_wen = 0;
      @(negedge i_clk);
      i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
      if (o_done) begin
        lat = c; done_req = o_mem_req;
        break;
      end
      if (o_mem_req) begin
        n_req++;
        m_addr = o_mem_addr; m_wdata = o_mem_wdata; m_mask = o_mem_mask; m_we = o_mem_we;
        if (req_i == gnt_dly) begin
          i_mem_gnt = 1;
          if (early_rv) begin i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_DEAD; end
        end
        req_i++;
      end
      if (o_dbg_state == ST_WAIT) begin
        wait_seen = 1;
        if (wait_i == rv_dly) begin i_mem_rvalid = 1; i_mem_rdata = rword; end
        wait_i++;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1; i_req_ren = 1; i_req_wen = 0; i_req_size = SZ_W; i_req_addr = 32'h40;
    i_req_wdata = '0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b, expected 0", o_stall); end
    i_req_ren = 0;
    @(negedge i_clk);
    i_rst = 0;
    @(negedge i_clk);
    checks++;
    if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected 0", o_dbg_state); end
    checks++;
    if ({o_stall, o_done, o_err, o_mem_req, o_mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, expected 00000", {o_stall, o_done, o_err, o_mem_req, o_mem_we});
    end
    checks++;
    if ({o_rdata, o_mem_addr, o_mem_wdata, o_mem_mask} !== 100'b0) begin
      errors++; $display("FAIL reset_buses: got rdata=%h addr=%h wdata=%h mask=%b, expected 0",
                         o_rdata, o_mem_addr, o_mem_wdata, o_mem_mask);
    end
  endtask

  // LB at 0x103: IDLE(request), REQ(gnt), WAIT(rvalid), DONE -> done in the 4th cycle.
  task automatic test_lb_sign();
    int lat, n_req; bit ws, st0, dreq; logic [31:0] ma, mw; logic [3:0] mm; logic we;
    exp_q.push_back({1'b0, 32'hFFFF_FF80});
    run_access(1, 0, SZ_B, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, lat, n_req, ws, st0, dreq, ma, mw, mm, we);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d, expected 3", lat); end
    checks++;
    if (st0 !== 1'b1) begin errors++; $display("FAIL lb_stall_idle: got %0b, expected 1", st0); end
    checks++;
    if (ma !== 32'h100 || we !== 1'b0) begin errors++; $display("FAIL lb_mem_addr: got %h we=%0b, expected 00000100 we=0", ma, we); end
  endtask

  task automatic test_sh_store();
    int lat, n_req; bit ws, st0, dreq; logic [31:0] ma, mw; logic [3:0] mm; logic we;
    exp_q.push_back({1'b0, 32'h0});
    run_access(0, 1, SZ_H, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, 0, lat, n_req, ws, st0, dreq, ma, mw, mm, we);
    checks++;
    if (mm !== 4'b1100) begin errors++; $display("FAIL sh_mask: got %b, expected 1100", mm); end
    checks++;
    if (mw !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h, expected abcdabcd", mw); end
    checks++;
    if (ma !== 32'h200 || we !== 1'b1) begin errors++; $display("FAIL sh_addr: got %h we=%0b, expected 00000200 we=1", ma, we); end
    checks++;
    if (ws !== 1'b0 || lat !== 2) begin errors++; $display("FAIL sh_no_wait: got wait=%0b lat=%0d, expected wait=0 lat=2", ws, lat); end
  endtask

  task automatic test_timeout();
    int lat, n_req; bit ws, st0, dreq; logic [31:0] ma, mw; logic [3:0] mm; logic we;
    exp_q.push_back({1'b1, 32'h0});
    run_access(1, 0, SZ_W, 32'h400, 32'h0, 32'h1234_5678, -1, 0, 0, lat, n_req, ws, st0, dreq, ma, mw, mm, we);
    checks++;
    if (n_req !== 4 || lat !== 5) begin errors++; $display("FAIL timeout_req_cycles: got req=%0d lat=%0d, expected req=4 lat=5", n_req, lat); end
    checks++;
    if (dreq !== 1'b0) begin errors++; $display("FAIL timeout_req_low: got %0b, expected 0", dreq); end
    // Grant on the first REQ cycle, rvalid never: REQ + 3 WAIT cycles exhaust the budget.
    exp_q.push_back({1'b1, 32'h0});
    run_access(1, 0, SZ_W, 32'h404, 32'h0, 32'h1234_5678, 0, -1, 0, lat, n_req, ws, st0, dreq, ma, mw, mm, we);
    checks++;
    if (lat !== 5 || ws !== 1'b1) begin errors++; $display("FAIL timeout_wait: got lat=%0d wait=%0b, expected lat=5 wait=1", lat, ws); end
  endtask

  task automatic test_early_rvalid();
    int lat, n_req; bit ws, st0, dreq; logic [31:0] ma, mw; logic [3:0] mm; logic we;
    exp_q.push_back({1'b0, 32'h0000_BEEF});
    run_access(1, 0, SZ_HU, 32'h102, 32'h0, 32'hBEEF_1234, 0, 1, 1, lat, n_req, ws, st0, dreq, ma, mw, mm, we);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL early_rvalid_latency: got %0d, expected 4", lat); end
  endtask

  task automatic test_misalign_lw();
    int lat, n_req; bit ws, st0, dreq; logic [31:0] ma, mw; logic [3:0] mm; logic we;
    exp_q.push_back(TRAP ? {1'b1, 32'h0} : {1'b0, 32'h1234_5678});
    run_access(1, 0, SZ_W, 32'h101, 32'h0, 32'h1234_5678, 0, 0, 0, lat, n_req, ws, st0, dreq, ma, mw, mm, we);
    checks++;
    if (TRAP && (n_req !== 0 || lat !== 1)) begin
      errors++; $display("FAIL lw_misalign_trap: got req=%0d lat=%0d, expected req=0 lat=1", n_req, lat);
    end else if (!TRAP && (ma !== 32'h100 || lat !== 3)) begin
      errors++; $display("FAIL lw_misalign_ignore: got addr=%h lat=%0d, expected 00000100 lat=3", ma, lat);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    i_req_ren = 1; i_req_size = SZ_W; i_req_addr = 32'h300;
    @(posedge i_clk); #1 i_req_ren = 0;
    @(negedge i_clk) i_mem_gnt = 1;
    @(negedge i_clk) i_mem_gnt = 0;
    checks++;
    if (o_dbg_state !== ST_WAIT) begin errors++; $display("FAIL rstmid_in_wait: got %0d, expected 2", o_dbg_state); end
    i_rst = 1;
    #1;
    checks++;
    if (o_dbg_state !== ST_IDLE || o_stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got state=%0d stall=%0b, expected 0/0", o_dbg_state, o_stall);
    end
    @(negedge i_clk);
    i_rst = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_F00D;
    bad = 0;
    repeat (4) begin
      @(negedge i_clk);
      i_mem_rvalid = 0;
      if (o_done !== 1'b0 || o_dbg_state !== ST_IDLE) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_late_rvalid: got done/activity after reset, expected idle"); end
  endtask

  // Request inputs stay high through DONE; DONE must not stall nor start another access.
  task automatic test_done_ignore();
    exp_q.push_back({1'b0, 32'h0});
    i_req_wen = 1; i_req_ren = 1; i_req_size = SZ_B; i_req_addr = 32'h1; i_req_wdata = 32'h5A;
    @(negedge i_clk);
    checks++;
    if (o_mem_mask !== 4'b0010 || o_mem_wdata !== 32'h5A5A_5A5A || o_mem_we !== 1'b1) begin
      errors++; $display("FAIL sb_lane: got mask=%b wdata=%h we=%0b, expected 0010 5a5a5a5a 1", o_mem_mask, o_mem_wdata, o_mem_we);
    end
    i_mem_gnt = 1;
    @(negedge i_clk);
    i_mem_gnt = 0;
    checks++;
    if (o_done !== 1'b1 || o_stall !== 1'b0) begin
      errors++; $display("FAIL done_stall: got done=%0b stall=%0b, expected 1/0", o_done, o_stall);
    end
    i_req_wen = 0; i_req_ren = 0;
    @(negedge i_clk);
    checks++;
    if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL done_to_idle: got %0d, expected 0", o_dbg_state); end
  endtask

  task automatic test_back_to_back();
    int lat, n_req; bit ws, st0, dreq; logic [31:0] ma, mw; logic [3:0] mm; logic we;
    logic [31:0] addr, word, wdata; logic [2:0] size; logic st, trap;
    logic [3:0] e_mask; logic [31:0] e_wdata;
    for (int k = 0; k < 24; k++) begin
      addr = $urandom(); word = $urandom(); wdata = $urandom();
      st = 1'($urandom_range(0, 1));
      size = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      trap = model_trap(size, addr);
      if (trap)    exp_q.push_back({1'b1, 32'h0});
      else if (st) exp_q.push_back({1'b0, 32'h0});
      else         exp_q.push_back({1'b0, model_load(size, addr, word)});
      run_access(1'($urandom_range(0, 1)) | ~st, st, size, addr, wdata, word,
                 $urandom_range(0, 1), $urandom_range(0, 1), 0,
                 lat, n_req, ws, st0, dreq, ma, mw, mm, we);
      checks++;
      if (trap && n_req !== 0) begin
        errors++; $display("FAIL b2b_trap_req[%0d]: got %0d requests, expected 0", k, n_req);
      end else if (!trap && (ma !== (addr & 32'hFFFF_FFFC) || we !== st)) begin
        errors++; $display("FAIL b2b_addr[%0d]: got %h we=%0b, expected %h we=%0b", k, ma, we, addr & 32'hFFFF_FFFC, st);
      end
      if (st && !trap) begin
        case (size)
          3'b000:  begin e_mask = 4'b0001 << addr[1:0]; e_wdata = {4{wdata[7:0]}}; end
          3'b001:  begin e_mask = addr[1] ? 4'b1100 : 4'b0011; e_wdata = {2{wdata[15:0]}}; end
          default: begin e_mask = 4'b1111; e_wdata = wdata; end
        endcase
        checks++;
        if (mm !== e_mask || mw !== e_wdata) begin
          errors++; $display("FAIL b2b_store[%0d]: got mask=%b wdata=%h, expected %b %h", k, mm, mw, e_mask, e_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_sh_store();
    test_timeout();
    test_early_rvalid();
    test_misalign_lw();
    test_reset_mid();
    test_done_ignore();
    test_back_to_back();
    repeat (2) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
